// File: rtl/sha1_pkg.sv
// Shared definitions for the SHA-1 message padder: FSM state encoding,
// block geometry constants, the padding marker word and a byte-count clamp.
// No ports; imported by sha1_byte_pad and sha1_msg_padder.
package sha1_pkg;

  typedef enum logic [2:0] {
    DATA  = 3'd0,
    PAD1  = 3'd1,
    ZERO  = 3'd2,
    LENHI = 3'd3,
    LENLO = 3'd4
  } state_t;

  localparam int          WORDS_PER_BLK = 16;
  localparam logic [3:0]  LEN_IDX_HI    = 4'd14;
  localparam logic [3:0]  LAST_IDX      = 4'(WORDS_PER_BLK - 1);
  localparam logic [31:0] PAD_WORD      = 32'h8000_0000;

  // Byte counts 5..7 cannot occur in a 32-bit word; they are read as a full word.
  function automatic logic [2:0] clamp_nbytes(input logic [2:0] n);
    return (n > 3'd4) ? 3'd4 : n;
  endfunction

endpackage

// File: rtl/sha1_byte_pad.sv
// Combinational last-word masker: keeps the valid leading bytes of a
// big-endian word, inserts 0x80 after them and zeroes the rest.
// Ports: in_data (message word), in_nbytes (valid bytes 0..7) -> pad_data.
module sha1_byte_pad
  import sha1_pkg::*;
(
  input  logic [31:0] in_data,
  input  logic [2:0]  in_nbytes,
  output logic [31:0] pad_data
);

  logic [2:0] nb;

  assign nb = clamp_nbytes(in_nbytes);

  always_comb begin
    pad_data = in_data;
    case (nb)
      3'd0:    pad_data = PAD_WORD;
      3'd1:    pad_data = {in_data[31:24], 8'h80, 16'h0000};
      3'd2:    pad_data = {in_data[31:16], 8'h80, 8'h00};
      3'd3:    pad_data = {in_data[31:8], 8'h80};
      default: pad_data = in_data;  // full word: 0x80 goes in the next word
    endcase
  end

endmodule

// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder: turns a byte-aligned word stream into the padded
// stream (message, 0x80, zeros, 64-bit bit length) pushed into a FIFO.
// Ports: clk/rstn; in_valid/in_ready/in_data/in_last/in_nbytes upstream;
//        fifo_full in; push/dout/blk_end/msg_end out (all combinational).
module sha1_msg_padder
  import sha1_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic [2:0]            in_nbytes,
  input  logic                  fifo_full,
  output logic                  push,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  blk_end,
  output logic                  msg_end
);

  state_t            state, state_nxt;
  logic [3:0]        widx;
  logic [LEN_W-1:0]  bitlen;
  logic [63:0]       len64;
  logic [31:0]       last_word;
  logic [2:0]        nb_eff;
  logic [5:0]        add_bits;
  logic              accept;

  sha1_byte_pad u_byte_pad (
    .in_data   (in_data),
    .in_nbytes (in_nbytes),
    .pad_data  (last_word)
  );

  // Length field is always 64 bits; counter bits beyond LEN_W read as zero.
  always_comb begin
    len64               = '0;
    len64[LEN_W-1:0]    = bitlen;
  end

  assign nb_eff   = clamp_nbytes(in_nbytes);
  assign add_bits = in_last ? {nb_eff, 3'b000} : 6'd32;
  assign accept   = in_valid & in_ready;
  assign blk_end  = push & (widx == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= DATA;
    else       state <= state_nxt;
  end

  // Next-state logic: every emitting state only advances on a real push
  always_comb begin
    state_nxt = state;
    case (state)
      DATA: begin
        if (in_valid && !fifo_full && in_last)
          state_nxt = (nb_eff == 3'd4) ? PAD1 : ZERO;
      end
      PAD1:  if (!fifo_full) state_nxt = ZERO;
      // Reaching index 14 needs no push, so it does not wait on fifo_full.
      ZERO:  if (widx == LEN_IDX_HI) state_nxt = LENHI;
      LENHI: if (!fifo_full) state_nxt = LENLO;
      LENLO: if (!fifo_full) state_nxt = DATA;
      default: state_nxt = DATA;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = 1'b0;
    push     = 1'b0;
    dout     = '0;
    msg_end  = 1'b0;
    case (state)
      DATA: begin
        in_ready = !fifo_full;
        push     = in_valid & !fifo_full;
        dout     = in_last ? last_word : in_data;
      end
      PAD1: begin
        push = !fifo_full;
        dout = PAD_WORD;
      end
      ZERO: begin
        push = !fifo_full && (widx != LEN_IDX_HI);
      end
      LENHI: begin
        push = !fifo_full;
        dout = len64[63:32];
      end
      LENLO: begin
        push    = !fifo_full;
        dout    = len64[31:0];
        msg_end = !fifo_full;
      end
      default: begin
        push = 1'b0;
      end
    endcase
  end

  // Word index within the current 512-bit block
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     widx <= 4'd0;
    else if (push) widx <= widx + 4'd1;
  end

  // Message bit length; cleared once the low length word has gone out
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      bitlen <= '0;
    else if (state == LENLO && push)
      bitlen <= '0;
    else if (accept)
      bitlen <= bitlen + LEN_W'(add_bits);
  end

endmodule

// File: tb/tb_sha1_msg_padder.sv
module tb_sha1_msg_padder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [2:0]  in_nbytes;
  logic        fifo_full;
  logic        push;
  logic [31:0] dout;
  logic        blk_end;
  logic        msg_end;

  int checks = 0;
  int errors = 0;

  logic [7:0]  msg[$];
  logic [31:0] exp_words[$];

  always #5 clk = ~clk;

  sha1_msg_padder #(.DATA_WIDTH(32), .LEN_W(64)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .fifo_full (fifo_full),
    .push      (push),
    .dout      (dout),
    .blk_end   (blk_end),
    .msg_end   (msg_end)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference: padded byte string per SHA-1 rules, regrouped into big-endian words.
  task automatic build_expected();
    logic [7:0]  pb[$];
    logic [63:0] len;
    pb  = msg;
    len = 64'(msg.size()) * 64'd8;
    pb.push_back(8'h80);
    while ((pb.size() % 64) != 56) pb.push_back(8'h00);
    for (int i = 7; i >= 0; i--) pb.push_back(8'(len >> (8 * i)));
    exp_words.delete();
    for (int w = 0; w < pb.size() / 4; w++)
      exp_words.push_back({pb[4*w], pb[4*w+1], pb[4*w+2], pb[4*w+3]});
  endtask

  // mode 0: no stalls, 1: random stalls/valid gaps, 2: two 5-cycle full windows
  task automatic run_msg(input string name, input int mode);
    int  nwords, sent, got, cyc, nb;
    bit  done, ff;
    logic [7:0] b;
    build_expected();
    nwords = (msg.size() == 0) ? 1 : (msg.size() + 3) / 4;
    sent = 0; got = 0; cyc = 0; done = 0;
    while (!done && cyc < 3000) begin
      case (mode)
        0:       ff = 1'b0;
        1:       ff = ($urandom_range(0, 3) == 0);
        default: ff = (cyc >= 2 && cyc < 7) || (cyc >= 22 && cyc < 27);
      endcase
      fifo_full = ff;
      if (sent < nwords) begin
        in_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_last  = (sent == nwords - 1);
        nb       = msg.size() - 4 * sent;
        if (nb > 4) nb = 4;
        for (int k = 0; k < 4; k++) begin
          b = (k < nb) ? msg[4*sent+k] : 8'($urandom);
          in_data[31-8*k -: 8] = b;
        end
        in_nbytes = 3'(nb);
        if (in_last && nb == 4) in_nbytes = 3'($urandom_range(4, 7));
        if (!in_last) in_nbytes = 3'($urandom);
      end else begin
        in_valid  = $urandom_range(0, 1) == 1;
        in_data   = $urandom;
        in_last   = $urandom_range(0, 1) == 1;
        in_nbytes = 3'($urandom);
      end
      @(negedge clk);
      check({name, ":in_ready"}, in_ready, (sent < nwords) && !ff);
      if (ff) check({name, ":push_full"}, push, 1'b0);
      if (push) begin
        if (got < exp_words.size()) begin
          check({name, ":dout"}, dout, exp_words[got]);
          check({name, ":flags"}, {blk_end, msg_end},
                {(got % 16) == 15, got == exp_words.size() - 1});
        end else begin
          check({name, ":extra_push"}, push, 1'b0);
        end
        got++;
        if (got == exp_words.size()) done = 1;
      end else begin
        check({name, ":idle_flags"}, {blk_end, msg_end}, 2'b00);
      end
      if (in_valid && in_ready) sent++;
      cyc++;
      @(posedge clk); #1;
    end
    if (!done) check({name, ":timeout"}, 1'b1, 1'b0);
    check({name, ":count"}, got, exp_words.size());
    in_valid  = 1'b0;
    fifo_full = 1'b0;
  endtask

  task automatic set_msg_bytes(input int n, input int base);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'(base + i));
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    in_nbytes = '0; fifo_full = 1'b0;
    #12;
    check("rst_push", push, 1'b0);
    check("rst_flags", {blk_end, msg_end}, 2'b00);
    check("rst_ready", in_ready, 1'b1);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    msg = '{8'h61, 8'h62, 8'h63};
    run_msg("abc", 0);
    msg.delete();
    run_msg("empty", 0);
    set_msg_bytes(55, 8'h10);
    run_msg("b55", 0);
    set_msg_bytes(56, 8'h20);
    run_msg("b56", 0);
    set_msg_bytes(56, 8'h30);
    run_msg("b56_stall", 2);
    msg = '{8'h61, 8'h62, 8'h63};
    run_msg("abc_stall", 2);
    set_msg_bytes(64, 8'h40);
    run_msg("b64", 1);

    // Abandon a message in the zero-fill phase
    in_valid = 1'b1; in_data = 32'h6162_6300; in_last = 1'b1; in_nbytes = 3'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    check("midrst_push", push, 1'b0);
    check("midrst_ready", in_ready, 1'b1);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    msg = '{8'h61, 8'h62, 8'h63};
    run_msg("abc_after_rst", 0);

    for (int t = 0; t < 25; t++) begin
      set_msg_bytes($urandom_range(0, 130), $urandom_range(0, 255));
      for (int i = 0; i < msg.size(); i++) msg[i] = 8'($urandom);
      run_msg("rand", $urandom_range(0, 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
